// File: rtl/io_ir_rx_if.sv
// io_ir_rx_if: main-bus bundle for the IR receiver peripheral.
//   bus_data            8-bit shared data bus, tri-stated by the responding slave
//   bus_addr            8-bit bus address
//   bus_we              write enable, active high
//   bus_interrupt_raise frame-received interrupt level from the peripheral
//   bus_interrupt_ack   one-cycle acknowledge from the CPU
interface io_ir_rx_if;
   wire  [7:0] bus_data;
   logic [7:0] bus_addr;
   logic       bus_we;
   logic       bus_interrupt_raise;
   logic       bus_interrupt_ack;

   modport master (
      inout  bus_data,
      output bus_addr,
      output bus_we,
      input  bus_interrupt_raise,
      output bus_interrupt_ack
   );

   modport slave (
      inout  bus_data,
      input  bus_addr,
      input  bus_we,
      output bus_interrupt_raise,
      input  bus_interrupt_ack
   );
endinterface

// File: rtl/io_ir_rx.sv
// io_ir_rx: memory-mapped IR command receiver.
// Decodes one start mark plus four command bits (MSB first) from a demodulated,
// active-low IR receiver output and exposes them through two bus registers:
//   BASE_ADDR     DATA   (read-only) {4'b0, cmd}
//   BASE_ADDR + 1 STATUS {5'b0, ovr, err, valid}; any write clears all three flags
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   ir_in  receiver-module output, 0 = carrier present (mark)
//   bus    main bus slave (data, address, write enable, interrupt raise/ack)
// Optional feature: define IR_RX_GLITCH_FILTER_EN to reject input pulses of 1-2 ticks.
module io_ir_rx #(
   parameter int unsigned PRESCALE   = 100,
   parameter int unsigned START_MIN  = 2000,
   parameter int unsigned BIT_THRESH = 1000,
   parameter int unsigned MARK_MIN   = 200,
   parameter int unsigned SPACE_MAX  = 3000,
   parameter logic [7:0]  BASE_ADDR  = 8'hA0
) (
   input logic        clk,
   input logic        reset,
   input logic        ir_in,
   io_ir_rx_if.slave  bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESCALE - 1);
   localparam logic [11:0]   START_MIN_C  = 12'(START_MIN);
   localparam logic [11:0]   BIT_THRESH_C = 12'(BIT_THRESH);
   localparam logic [11:0]   MARK_MIN_C   = 12'(MARK_MIN);
   localparam logic [11:0]   SPACE_MAX_C  = 12'(SPACE_MAX);
   localparam logic [7:0]    STATUS_ADDR  = BASE_ADDR + 8'd1;

   typedef enum logic [1:0] {StIdle, StStart, StSpace, StMark} state_e;

   // ---------------------------------------------------------------------------
   // Input synchroniser and sample tick
   // ---------------------------------------------------------------------------
   logic [1:0]    sync_q;
   logic          active;
   logic [PW-1:0] presc_q;
   logic          tick;

   assign active = ~sync_q[1];
   assign tick   = (presc_q == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         presc_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], ir_in};
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Level seen by the decoder, only meaningful on tick
   // ---------------------------------------------------------------------------
   logic level;

`ifdef IR_RX_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   // The filtered level flips only once the current and two previous samples agree.
   always_comb begin
      level = filt_q;
      if ({hist_q, active} == 3'b111) begin
         level = 1'b1;
      end else if ({hist_q, active} == 3'b000) begin
         level = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q <= 2'b00;
         filt_q <= 1'b0;
      end else if (tick) begin
         hist_q <= {hist_q[0], active};
         filt_q <= level;
      end
   end
`else
   assign level = active;
`endif

   // ---------------------------------------------------------------------------
   // Frame decoder FSM
   // ---------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic [11:0] cnt_q, cnt_d, cnt_inc;
   logic [2:0]  bitcnt_q, bitcnt_d;
   logic [3:0]  cmd_q, cmd_d;
   logic        commit;
   logic        err_set;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      cmd_d    = cmd_q;
      commit   = 1'b0;
      err_set  = 1'b0;
      cnt_inc  = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
      if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (level) begin
                  state_d = StStart;
                  cnt_d   = '0;
               end
            end
            StStart: begin
               if (level) begin
                  cnt_d = cnt_inc;
               end else if (cnt_q >= START_MIN_C) begin
                  state_d  = StSpace;
                  cnt_d    = '0;
                  bitcnt_d = '0;
                  cmd_d    = '0;
               end else begin
                  // Short burst: treated as noise, no error.
                  state_d = StIdle;
               end
            end
            StSpace: begin
               if (level) begin
                  state_d = StMark;
                  cnt_d   = '0;
               end else if (cnt_inc >= SPACE_MAX_C) begin
                  err_set = 1'b1;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            StMark: begin
               if (level) begin
                  if (cnt_inc >= START_MIN_C) begin
                     err_set = 1'b1;
                     state_d = StIdle;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else if (cnt_q < MARK_MIN_C) begin
                  err_set = 1'b1;
                  state_d = StIdle;
               end else begin
                  cmd_d    = {cmd_q[2:0], (cnt_q >= BIT_THRESH_C)};
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd3) begin
                     commit  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StSpace;
                     cnt_d   = '0;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         cmd_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         cmd_q    <= cmd_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers, interrupt and bus read port
   // ---------------------------------------------------------------------------
   logic [7:0] data_q;
   logic       valid_q, err_q, ovr_q, raise_q;
   logic       wr_status;
   logic       rd_hit;
   logic       rd_en_q;
   logic [7:0] rd_data_q;
   logic [7:0] status;

   assign status    = {5'b0, ovr_q, err_q, valid_q};
   assign wr_status = bus.bus_we && (bus.bus_addr == STATUS_ADDR);
   assign rd_hit    = !bus.bus_we &&
                      ((bus.bus_addr == BASE_ADDR) || (bus.bus_addr == STATUS_ADDR));

   always_ff @(posedge clk) begin
      if (!reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         ovr_q     <= 1'b0;
         raise_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_data_q <= '0;
      end else begin
         // Flag sets beat a simultaneous STATUS clear.
         if (commit) begin
            data_q <= {4'b0, cmd_d};
         end
         valid_q <= commit | (valid_q & ~wr_status);
         ovr_q   <= (commit & valid_q) | (ovr_q & ~wr_status);
         err_q   <= err_set | (err_q & ~wr_status);
         if (commit) begin
            raise_q <= 1'b1;
         end else if (bus.bus_interrupt_ack) begin
            raise_q <= 1'b0;
         end
         rd_en_q   <= rd_hit;
         rd_data_q <= (bus.bus_addr == STATUS_ADDR) ? status : data_q;
      end
   end

   assign bus.bus_data            = rd_en_q ? rd_data_q : 8'hzz;
   assign bus.bus_interrupt_raise = raise_q;

endmodule

// File: tb/tb_io_ir_rx.sv
// tb_io_ir_rx: randomized + directed bench for io_ir_rx.
// Stimulus is a list of mark/space durations in ticks; a duration-level reference
// model decodes the list and tracks DATA/STATUS/interrupt expectations.
module tb_io_ir_rx;

   localparam int unsigned PRESCALE   = 3;
   localparam int unsigned START_MIN  = 30;
   localparam int unsigned BIT_THRESH = 16;
   localparam int unsigned MARK_MIN   = 6;
   localparam int unsigned SPACE_MAX  = 40;
   localparam logic [7:0]  BASE       = 8'hA0;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ir_in = 1'b1;

   io_ir_rx_if bus ();

   io_ir_rx #(
      .PRESCALE   (PRESCALE),
      .START_MIN  (START_MIN),
      .BIT_THRESH (BIT_THRESH),
      .MARK_MIN   (MARK_MIN),
      .SPACE_MAX  (SPACE_MAX),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ir_in (ir_in),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [7:0] m_data;
   logic       m_valid, m_err, m_ovr, m_raise;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
      m_raise = 1'b0;
   endtask

   // Decode a mark/space duration list (first entry is a mark) by the frame rules.
   task automatic model_frame(input int segs[$]);
      int   lens[$];
      bit   lvl[$];
      int   st;
      int   nb;
      logic [3:0] cmd;
      st  = 0;
      nb  = 0;
      cmd = 4'h0;
      lens.push_back(1000);
      lvl.push_back(1'b0);
      foreach (segs[i]) begin
         lens.push_back(segs[i]);
         lvl.push_back((i % 2) == 0);
      end
      lens.push_back(1000);
      lvl.push_back(1'b0);
`ifdef IR_RX_GLITCH_FILTER_EN
      begin
         int i;
         i = 1;
         while (i < lens.size() - 1) begin
            if (lens[i] < 3) begin
               lens[i-1] = lens[i-1] + lens[i] + lens[i+1];
               lens.delete(i+1);
               lens.delete(i);
               lvl.delete(i+1);
               lvl.delete(i);
            end else begin
               i++;
            end
         end
      end
`endif
      for (int k = 0; k < lens.size(); k++) begin
         if (st == 0) begin
            if (lvl[k] && lens[k] >= int'(START_MIN)) begin
               st  = 1;
               nb  = 0;
               cmd = 4'h0;
            end
         end else if (!lvl[k]) begin
            if (lens[k] >= int'(SPACE_MAX)) begin
               m_err = 1'b1;
               st    = 0;
            end
         end else if (lens[k] < int'(MARK_MIN) || lens[k] >= int'(START_MIN)) begin
            m_err = 1'b1;
            st    = 0;
         end else begin
            cmd = {cmd[2:0], lens[k] >= int'(BIT_THRESH)};
            nb++;
            if (nb == 4) begin
               if (m_valid) m_ovr = 1'b1;
               m_valid = 1'b1;
               m_raise = 1'b1;
               m_data  = {4'h0, cmd};
               st      = 0;
            end
         end
      end
   endtask

   task automatic drive(input bit mark, input int ticks);
      ir_in = mark ? 1'b0 : 1'b1;
      repeat (ticks * int'(PRESCALE)) @(negedge clk);
   endtask

   task automatic play(input int segs[$]);
      foreach (segs[i]) drive((i % 2) == 0, segs[i]);
      drive(1'b0, int'(SPACE_MAX) + 8);
      model_frame(segs);
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [7:0] val);
      @(negedge clk);
      bus.bus_addr = addr;
      bus.bus_we   = 1'b0;
      @(negedge clk);
      val          = bus.bus_data;
      bus.bus_addr = 8'h00;
   endtask

   task automatic bus_write(input logic [7:0] addr);
      @(negedge clk);
      bus.bus_addr = addr;
      bus.bus_we   = 1'b1;
      @(negedge clk);
      bus.bus_we   = 1'b0;
      bus.bus_addr = 8'h00;
      if (addr == BASE + 8'd1) begin
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_ovr   = 1'b0;
      end
   endtask

   task automatic ack();
      @(negedge clk);
      bus.bus_interrupt_ack = 1'b1;
      @(negedge clk);
      bus.bus_interrupt_ack = 1'b0;
      m_raise = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      logic [7:0] v;
      bus_read(BASE, v);
      check_eq({tag, "_data"}, v, m_data);
      bus_read(BASE + 8'd1, v);
      check_eq({tag, "_status"}, v, {5'b0, m_ovr, m_err, m_valid});
      check_eq({tag, "_raise"}, {7'b0, bus.bus_interrupt_raise}, {7'b0, m_raise});
   endtask

   task automatic check_lit(input string tag, input logic [7:0] d, input logic [7:0] s,
                            input logic r);
      logic [7:0] v;
      bus_read(BASE, v);
      check_eq({tag, "_data_lit"}, v, d);
      bus_read(BASE + 8'd1, v);
      check_eq({tag, "_status_lit"}, v, s);
      check_eq({tag, "_raise_lit"}, {7'b0, bus.bus_interrupt_raise}, {7'b0, r});
   endtask

   int segs[$];

   initial begin
      bus.bus_addr          = 8'h00;
      bus.bus_we            = 1'b0;
      bus.bus_interrupt_ack = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_lit("reset", 8'h00, 8'h00, 1'b0);

      // Basic frame 1010
      segs = '{35, 8, 20, 8, 10, 8, 20, 8, 10};
      play(segs);
      check_lit("frame_a", 8'h0A, 8'h01, 1'b1);
      check_regs("frame_a_m");
      ack();
      check_lit("frame_a_ack", 8'h0A, 8'h01, 1'b0);

      // Writes to DATA are ignored; STATUS write clears
      bus_write(BASE);
      bus_write(BASE + 8'd1);
      check_lit("clear", 8'h0A, 8'h00, 1'b0);

      // Short start mark: silently ignored
      segs = '{20, 8, 20, 8, 10, 8, 20, 8, 10};
      play(segs);
      check_lit("short_start", 8'h0A, 8'h00, 1'b0);

      // Valid start then space timeout
      segs = '{35};
      play(segs);
      check_lit("space_to", 8'h0A, 8'h02, 1'b0);
      bus_write(BASE + 8'd1);

      // Two frames without clearing: overrun
      segs = '{35, 8, 10, 8, 20, 8, 10, 8, 20};
      play(segs);
      segs = '{35, 8, 10, 8, 10, 8, 20, 8, 20};
      play(segs);
      check_lit("ovr", 8'h03, 8'h05, 1'b1);
      bus_write(BASE + 8'd1);
      check_lit("ovr_clr", 8'h03, 8'h00, 1'b1);
      ack();

      // Reset during the third data mark, then a full frame
      drive(1'b1, 35); drive(1'b0, 8); drive(1'b1, 20); drive(1'b0, 8);
      drive(1'b1, 10); drive(1'b0, 8); drive(1'b1, 5);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      reset = 1'b1;
      drive(1'b0, 50);
      check_lit("mid_reset", 8'h00, 8'h00, 1'b0);
      segs = '{35, 8, 20, 8, 20, 8, 20, 8, 20};
      play(segs);
      check_lit("after_reset", 8'h0F, 8'h01, 1'b1);
      ack();
      bus_write(BASE + 8'd1);

      // Two-tick inactive glitch inside the first data mark
      segs = '{35, 8, 3, 2, 15, 8, 20, 8, 10, 8, 20};
      play(segs);
`ifdef IR_RX_GLITCH_FILTER_EN
      check_lit("glitch", 8'h0D, 8'h01, 1'b1);
`else
      check_lit("glitch", 8'h0F, 8'h02, 1'b0);
`endif
      check_regs("glitch_m");
      ack();
      bus_write(BASE + 8'd1);

      // Randomized frames against the reference model
      for (int f = 0; f < 30; f++) begin
         segs.delete();
         if ($urandom_range(0, 7) == 0)
            segs.push_back(int'($urandom_range(MARK_MIN + 2, START_MIN - 3)));
         else
            segs.push_back(int'($urandom_range(START_MIN + 2, START_MIN + 10)));
         for (int b = 0; b < 4; b++) begin
            int k;
            if ($urandom_range(0, 15) == 0) segs.push_back(int'(SPACE_MAX) + 3);
            else segs.push_back(int'($urandom_range(4, 20)));
            k = int'($urandom_range(0, 15));
            if (k == 0) begin
`ifdef IR_RX_GLITCH_FILTER_EN
               segs.push_back(int'($urandom_range(3, MARK_MIN - 2)));
`else
               segs.push_back(int'($urandom_range(1, MARK_MIN - 2)));
`endif
            end else if (k % 2 == 1) begin
               segs.push_back(int'($urandom_range(BIT_THRESH + 2, START_MIN - 3)));
            end else begin
               segs.push_back(int'($urandom_range(MARK_MIN + 2, BIT_THRESH - 2)));
            end
         end
         play(segs);
         check_regs($sformatf("rnd%0d", f));
         if ($urandom_range(0, 2) == 0) ack();
         if ($urandom_range(0, 3) == 0) bus_write(BASE + 8'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
